// File: rtl/spu_pcx_sched.sv
// PCX request scheduler: arbitrates SPU load/store requesters, sequences the packet register and
// tracks LSU credits. Define SPU_PCX_RR_ARB_EN for round-robin arbitration (default: load-first).
module spu_pcx_sched #(
  parameter int unsigned MAX_LD_OUTST = 2,
  parameter int unsigned MAX_ST_OUTST = 2
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       spu_mald_req,
  input  logic       spu_mast_req,
  input  logic       lsu_spu_pcx_ack,
  input  logic       lsu_spu_ld_rtn,
  input  logic       lsu_spu_st_ack,
  output logic       spu_wen_pcx_wen,
  output logic       spu_wen_pcx_7170_sel,
  output logic       spu_pcx_req_vld,
  output logic       spu_pcx_req_st,
  output logic       spu_mald_gnt,
  output logic       spu_mast_gnt,
  output logic [2:0] spu_pcx_ld_outst,
  output logic [2:0] spu_pcx_st_outst,
  output logic       spu_pcx_idle
);

  typedef enum logic [1:0] {StIdle, StCapt, StReq} state_e;

  state_e     state_q, state_d;
  logic       req_st_q, req_st_d;
  logic [2:0] ld_outst_q, ld_outst_d;
  logic [2:0] st_outst_q, st_outst_d;
  logic       idle_q;
  logic       ld_elig, st_elig, grant, win_st, ack_taken;
  logic       ld_inc, ld_dec, st_inc, st_dec;

  assign ld_elig   = spu_mald_req && (ld_outst_q < 3'(MAX_LD_OUTST));
  assign st_elig   = spu_mast_req && (st_outst_q < 3'(MAX_ST_OUTST));
  assign grant     = (state_q == StIdle) && (ld_elig || st_elig);
  assign ack_taken = (state_q == StReq) && lsu_spu_pcx_ack;

`ifdef SPU_PCX_RR_ARB_EN
  // ptr_q = 1 gives the store side priority when both are eligible.
  logic ptr_q, ptr_d;

  assign win_st = st_elig && (!ld_elig || ptr_q);

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = ~win_st;
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign win_st = st_elig && !ld_elig;
`endif

  // Next state and packet type
  always_comb begin
    state_d  = state_q;
    req_st_d = req_st_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d  = StCapt;
          req_st_d = win_st;
        end
      end
      StCapt:  state_d = StReq;
      StReq:   if (lsu_spu_pcx_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A return with nothing outstanding is spurious and dropped before the sum.
  always_comb begin
    ld_inc     = ack_taken && !req_st_q;
    st_inc     = ack_taken && req_st_q;
    ld_dec     = lsu_spu_ld_rtn && (ld_outst_q != 3'd0);
    st_dec     = lsu_spu_st_ack && (st_outst_q != 3'd0);
    ld_outst_d = ld_outst_q + {2'b00, ld_inc} - {2'b00, ld_dec};
    st_outst_d = st_outst_q + {2'b00, st_inc} - {2'b00, st_dec};
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      req_st_q   <= 1'b0;
      ld_outst_q <= 3'd0;
      st_outst_q <= 3'd0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_st_q   <= req_st_d;
      ld_outst_q <= ld_outst_d;
      st_outst_q <= st_outst_d;
      idle_q     <= (state_d == StIdle) && (ld_outst_d == 3'd0) && (st_outst_d == 3'd0);
    end
  end

  always_comb begin
    spu_wen_pcx_wen      = (state_q == StCapt);
    spu_wen_pcx_7170_sel = (state_q == StCapt);
    spu_pcx_req_vld      = (state_q == StReq);
    spu_pcx_req_st       = req_st_q;
    spu_mald_gnt         = (state_q == StCapt) && !req_st_q;
    spu_mast_gnt         = (state_q == StCapt) && req_st_q;
    spu_pcx_ld_outst     = ld_outst_q;
    spu_pcx_st_outst     = st_outst_q;
    spu_pcx_idle         = idle_q;
  end

endmodule
